// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall bit indices,
// stall encodings, FSM states and control-level constants.
package pipe_ctrl_pkg;

  localparam int unsigned INST_ADDR_W = 32;

  localparam logic RST_ENABLE      = 1'b1;
  localparam logic STALLREQ_ENABLE = 1'b1;
  localparam logic FLUSH_ENABLE    = 1'b1;
  localparam logic FLUSH_DISABLE   = 1'b0;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;

  // Bit positions within stall_o, {wb,mem,ex,id,if,pc}
  localparam int unsigned STALL_BIT_PC  = 0;
  localparam int unsigned STALL_BIT_IF  = 1;
  localparam int unsigned STALL_BIT_ID  = 2;
  localparam int unsigned STALL_BIT_EX  = 3;
  localparam int unsigned STALL_BIT_MEM = 4;
  localparam int unsigned STALL_BIT_WB  = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_STALL      = 2'b01,
    ST_FLUSH_PEND = 2'b10,
    ST_FLUSH      = 2'b11
  } state_t;

  // Deepest requesting stage wins; everything upstream of it is held.
  function automatic logic [5:0] stall_encode(input logic id, input logic ex,
                                              input logic mem);
    logic [5:0] enc;
    enc = STALL_NONE;
    if (mem == STALLREQ_ENABLE)     enc = STALL_MEM;
    else if (ex == STALLREQ_ENABLE) enc = STALL_EX;
    else if (id == STALLREQ_ENABLE) enc = STALL_ID;
    return enc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for pipe_ctrl: stalled cycles and flush pulses.
// Instantiated only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush_pulse,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall != STALL_NONE) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_pulse == FLUSH_ENABLE) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles_o = (rst == RST_ENABLE) ? '0 : stall_cycles_q;
  assign flush_count_o  = (rst == RST_ENABLE) ? '0 : flush_count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: stall vector, registered flush
// with redirect PC, and sticky stall timeout. PIPE_CTRL_PERF_EN adds counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id_i,
  input  logic                   stallreq_ex_i,
  input  logic                   stallreq_mem_i,
  input  logic                   flushreq_i,
  input  logic [INST_ADDR_W-1:0] flush_pc_i,
  output logic [5:0]             stall_o,
  output logic                   flush_o,
  output logic [INST_ADDR_W-1:0] new_pc_o,
  output logic                   timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]            stall_cycles_o,
  output logic [31:0]            flush_count_o
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(STALL_TIMEOUT);

  state_t                 state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_latch_q, pc_latch_d;
  logic [INST_ADDR_W-1:0] new_pc_q;
  logic                   flush_q;
  logic                   timeout_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [5:0]             stall_raw;
  logic                   any_req;

  assign any_req = stallreq_id_i | stallreq_ex_i | stallreq_mem_i;

  always_comb begin
    state_d    = state_q;
    pc_latch_d = pc_latch_q;
    stall_raw  = STALL_NONE;
    unique case (state_q)
      ST_RUN, ST_STALL: begin
        stall_raw = stall_encode(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
        if (flushreq_i) begin
          pc_latch_d = flush_pc_i;
          state_d    = stallreq_mem_i ? ST_FLUSH_PEND : ST_FLUSH;
        end else if (any_req) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH_PEND: begin
        // Only the outstanding memory access matters; ID/EX are about to be squashed.
        if (stallreq_mem_i) stall_raw = STALL_MEM;
        if (flushreq_i) pc_latch_d = flush_pc_i;
        if (!stallreq_mem_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (stall_raw != STALL_NONE) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= ST_RUN;
      pc_latch_q <= ZERO_WORD;
      new_pc_q   <= ZERO_WORD;
      flush_q    <= FLUSH_DISABLE;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_latch_q <= pc_latch_d;
      flush_q    <= (state_d == ST_FLUSH) ? FLUSH_ENABLE : FLUSH_DISABLE;
      if (state_d == ST_FLUSH) new_pc_q <= pc_latch_d;
      cnt_q      <= cnt_d;
      if (cnt_d == TIMEOUT_CNT) timeout_q <= 1'b1;
    end
  end

  // Reset overrides every output in the same cycle, not only after the edge.
  assign stall_o   = (rst == RST_ENABLE) ? STALL_NONE    : stall_raw;
  assign flush_o   = (rst == RST_ENABLE) ? FLUSH_DISABLE : flush_q;
  assign new_pc_o  = (rst == RST_ENABLE) ? ZERO_WORD     : new_pc_q;
  assign timeout_o = (rst == RST_ENABLE) ? 1'b0          : timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall_o),
    .flush_pulse    (flush_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven scenarios with a queue of
// expected outputs per cycle.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i, flushreq_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_o, flush_count_o;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_TIMEOUT(8), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .flushreq_i     (flushreq_i),
    .flush_pc_i     (flush_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .timeout_o      (timeout_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
`endif
  );

  // One row = inputs for a cycle plus the outputs expected in that cycle.
  typedef struct {
    logic        r, id, ex, mem, fr;
    logic [31:0] pc;
    logic [5:0]  stall;
    logic        flush;
    logic        chk;
    logic [31:0] npc;
    logic        tmo;
  } row_t;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        chk;
    logic [31:0] npc;
    logic        tmo;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic drive(input row_t t);
    rst            = t.r;
    stallreq_id_i  = t.id;
    stallreq_ex_i  = t.ex;
    stallreq_mem_i = t.mem;
    flushreq_i     = t.fr;
    flush_pc_i     = t.pc;
    sb.push_back('{t.stall, t.flush, t.chk, t.npc, t.tmo});
    #1;
  endtask

  task automatic test_reset();
    row_t t[3];
    exp_t e;
    t = '{
      '{H, H, H, H, H, 32'h44, STALL_NONE, L, H, 32'h0, L},
      '{H, H, H, H, H, 32'h44, STALL_NONE, L, H, 32'h0, L},
      '{L, L, L, L, L, 32'h0,  STALL_NONE, L, H, 32'h0, L}
    };
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      vectors++; if (stall_o !== e.stall) begin miscompares++; $display("FAIL reset[%0d] stall_o got=%b exp=%b", i, stall_o, e.stall); end
      vectors++; if (flush_o !== e.flush) begin miscompares++; $display("FAIL reset[%0d] flush_o got=%b exp=%b", i, flush_o, e.flush); end
      vectors++; if (timeout_o !== e.tmo) begin miscompares++; $display("FAIL reset[%0d] timeout_o got=%b exp=%b", i, timeout_o, e.tmo); end
      if (e.chk) begin
        vectors++; if (new_pc_o !== e.npc) begin miscompares++; $display("FAIL reset[%0d] new_pc_o got=%h exp=%h", i, new_pc_o, e.npc); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_id();
    row_t t[5];
    exp_t e;
    t = '{
      '{L, H, L, L, L, 32'h0, STALL_ID,   L, L, 32'h0, L},
      '{L, H, L, L, L, 32'h0, STALL_ID,   L, L, 32'h0, L},
      '{L, H, L, L, L, 32'h0, STALL_ID,   L, L, 32'h0, L},
      '{L, L, L, L, L, 32'h0, STALL_NONE, L, L, 32'h0, L},
      '{L, L, L, L, L, 32'h0, STALL_NONE, L, L, 32'h0, L}
    };
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      vectors++; if (stall_o !== e.stall) begin miscompares++; $display("FAIL stall_id[%0d] stall_o got=%b exp=%b", i, stall_o, e.stall); end
      vectors++; if (flush_o !== e.flush) begin miscompares++; $display("FAIL stall_id[%0d] flush_o got=%b exp=%b", i, flush_o, e.flush); end
      vectors++; if (timeout_o !== e.tmo) begin miscompares++; $display("FAIL stall_id[%0d] timeout_o got=%b exp=%b", i, timeout_o, e.tmo); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_prio();
    row_t t[5];
    exp_t e;
    t = '{
      '{L, H, L, H, L, 32'h0, STALL_MEM,  L, L, 32'h0, L},
      '{L, H, L, L, L, 32'h0, STALL_ID,   L, L, 32'h0, L},
      '{L, H, H, L, L, 32'h0, STALL_EX,   L, L, 32'h0, L},
      '{L, L, L, L, L, 32'h0, STALL_NONE, L, L, 32'h0, L},
      '{L, L, L, L, L, 32'h0, STALL_NONE, L, L, 32'h0, L}
    };
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      vectors++; if (stall_o !== e.stall) begin miscompares++; $display("FAIL stall_prio[%0d] stall_o got=%b exp=%b", i, stall_o, e.stall); end
      vectors++; if (flush_o !== e.flush) begin miscompares++; $display("FAIL stall_prio[%0d] flush_o got=%b exp=%b", i, flush_o, e.flush); end
      @(posedge clk); #1;
    end
  endtask

  // Includes a flush request and ID stall arriving during FLUSH: both ignored there.
  task automatic test_flush();
    row_t t[5];
    exp_t e;
    t = '{
      '{L, L, L, L, H, 32'h40, STALL_NONE, L, L, 32'h0,  L},
      '{L, H, L, L, H, 32'h99, STALL_NONE, H, H, 32'h40, L},
      '{L, H, L, L, L, 32'h0,  STALL_ID,   L, H, 32'h40, L},
      '{L, L, L, L, L, 32'h0,  STALL_NONE, L, H, 32'h40, L},
      '{L, L, L, L, L, 32'h0,  STALL_NONE, L, H, 32'h40, L}
    };
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      vectors++; if (stall_o !== e.stall) begin miscompares++; $display("FAIL flush[%0d] stall_o got=%b exp=%b", i, stall_o, e.stall); end
      vectors++; if (flush_o !== e.flush) begin miscompares++; $display("FAIL flush[%0d] flush_o got=%b exp=%b", i, flush_o, e.flush); end
      if (e.chk) begin
        vectors++; if (new_pc_o !== e.npc) begin miscompares++; $display("FAIL flush[%0d] new_pc_o got=%h exp=%h", i, new_pc_o, e.npc); end
      end
      @(posedge clk); #1;
    end
  endtask

  // MEM stall for 4 cycles, two redirects while pending; the later one wins.
  task automatic test_flush_pend();
    row_t t[7];
    exp_t e;
    t = '{
      '{L, L, L, H, H, 32'h80, STALL_MEM,  L, L, 32'h0,  L},
      '{L, L, L, H, H, 32'hC0, STALL_MEM,  L, L, 32'h0,  L},
      '{L, H, L, H, L, 32'h0,  STALL_MEM,  L, L, 32'h0,  L},
      '{L, L, L, H, L, 32'h0,  STALL_MEM,  L, L, 32'h0,  L},
      '{L, L, H, L, L, 32'h0,  STALL_NONE, L, L, 32'h0,  L},
      '{L, L, L, L, L, 32'h0,  STALL_NONE, H, H, 32'hC0, L},
      '{L, L, L, L, L, 32'h0,  STALL_NONE, L, H, 32'hC0, L}
    };
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      vectors++; if (stall_o !== e.stall) begin miscompares++; $display("FAIL flush_pend[%0d] stall_o got=%b exp=%b", i, stall_o, e.stall); end
      vectors++; if (flush_o !== e.flush) begin miscompares++; $display("FAIL flush_pend[%0d] flush_o got=%b exp=%b", i, flush_o, e.flush); end
      if (e.chk) begin
        vectors++; if (new_pc_o !== e.npc) begin miscompares++; $display("FAIL flush_pend[%0d] new_pc_o got=%h exp=%h", i, new_pc_o, e.npc); end
      end
      @(posedge clk); #1;
    end
  endtask

  // STALL_TIMEOUT=8: the flag is set by the edge closing the 8th stall cycle.
  task automatic test_timeout();
    row_t t;
    exp_t e;
    for (int k = 1; k <= 13; k++) begin
      t = '{L, L, (k <= 10), L, L, 32'h0, (k <= 10) ? STALL_EX : STALL_NONE,
            L, L, 32'h0, (k >= 9)};
      drive(t);
      e = sb.pop_front();
      vectors++; if (stall_o !== e.stall) begin miscompares++; $display("FAIL timeout[%0d] stall_o got=%b exp=%b", k, stall_o, e.stall); end
      vectors++; if (timeout_o !== e.tmo) begin miscompares++; $display("FAIL timeout[%0d] timeout_o got=%b exp=%b", k, timeout_o, e.tmo); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_pend();
    row_t t[6];
    exp_t e;
    t = '{
      '{L, L, L, H, H, 32'hE0, STALL_MEM,  L, L, 32'h0, H},
      '{L, L, L, H, L, 32'h0,  STALL_MEM,  L, L, 32'h0, H},
      '{H, L, L, H, L, 32'h0,  STALL_NONE, L, H, 32'h0, L},
      '{L, L, L, L, L, 32'h0,  STALL_NONE, L, H, 32'h0, L},
      '{L, L, L, L, L, 32'h0,  STALL_NONE, L, H, 32'h0, L},
      '{L, L, L, L, L, 32'h0,  STALL_NONE, L, H, 32'h0, L}
    };
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      vectors++; if (stall_o !== e.stall) begin miscompares++; $display("FAIL reset_pend[%0d] stall_o got=%b exp=%b", i, stall_o, e.stall); end
      vectors++; if (flush_o !== e.flush) begin miscompares++; $display("FAIL reset_pend[%0d] flush_o got=%b exp=%b", i, flush_o, e.flush); end
      vectors++; if (timeout_o !== e.tmo) begin miscompares++; $display("FAIL reset_pend[%0d] timeout_o got=%b exp=%b", i, timeout_o, e.tmo); end
      if (e.chk) begin
        vectors++; if (new_pc_o !== e.npc) begin miscompares++; $display("FAIL reset_pend[%0d] new_pc_o got=%h exp=%h", i, new_pc_o, e.npc); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    stallreq_id_i  = 1'b0;
    stallreq_ex_i  = 1'b0;
    stallreq_mem_i = 1'b0;
    flushreq_i     = 1'b0;
    flush_pc_i     = '0;
    @(posedge clk); #1;
    test_reset();
    test_stall_id();
    test_stall_prio();
    test_flush();
    test_flush_pend();
    test_timeout();
    test_reset_pend();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. Collects stall requests from ID, EX and MEM and flush/redirect requests from branch/jump resolution. Drives one stall vector to PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus a registered flush with redirect PC. Holds a flush until an in-flight memory access completes and flags runaway stalls.

## Interface
- STALL_TIMEOUT, 1024: consecutive stall cycles that set `timeout_o`
- CNT_W, 16: width of the stall-duration counter; must satisfy 2^CNT_W > STALL_TIMEOUT
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high (`RST_ENABLE` = 1'b1)
- stallreq_id_i  in  1  ID needs to hold (hazard), `STALLREQ_ENABLE` = 1
- stallreq_ex_i  in  1  EX multi-cycle op busy
- stallreq_mem_i  in  1  MEM access not complete
- flushreq_i  in  1  redirect request, single-cycle pulse
- flush_pc_i  in  `INST_ADDR_BUS`  redirect target, valid with flushreq_i
- stall_o  out  6  {wb,mem,ex,id,if,pc}, bit 0 = pc
- flush_o  out  1  clear IF/ID, ID/EX, EX/MEM this cycle
- new_pc_o  out  `INST_ADDR_BUS`  PC to load when flush_o = 1
- timeout_o  out  1  sticky stall-timeout flag

## Operation
- Stall encoding is a priority mux, MEM highest:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - none → 6'b000000
- Lower stages keep flowing, so a bubble enters the first un-stalled stage.
- FSM states: RUN, STALL, FLUSH_PEND, FLUSH. Reset state is RUN.
- RUN and STALL transitions:
  - any stallreq → STALL
  - flushreq_i with stallreq_mem_i = 0 → FLUSH; latch flush_pc_i
  - flushreq_i with stallreq_mem_i = 1 → FLUSH_PEND; latch flush_pc_i
  - flush wins over STALL entry
- STALL: stall_o follows the requests each cycle. Return to RUN in the cycle after all requests are low.
- FLUSH_PEND:
  - stall_o = 6'b011111 while stallreq_mem_i is high, otherwise 6'b000000.
  - ID/EX requests are ignored.
  - The cycle after stallreq_mem_i is low → FLUSH.
  - A further flushreq_i overwrites the latched PC (latest redirect wins).
- FLUSH: flush_o = 1 and new_pc_o = latched PC for exactly one cycle; stall_o = 0. Next state is always RUN.
  - flushreq_i arriving during FLUSH is dropped, because its source stage is being squashed.
  - stallreq_* arriving during FLUSH is ignored for that cycle and honoured from RUN.
- Stall counter:
  - Increments every cycle stall_o != 0 and saturates at all-ones.
  - Clears on any cycle with stall_o = 0.
  - When it reaches STALL_TIMEOUT, timeout_o is set. It clears only on rst.

## Timing
- stall_o is combinational from requests and state, 0 cycles latency. The stall applies in the same cycle as the request.
- flush_o and new_pc_o are registered:
  - flushreq_i at cycle N with no MEM stall gives flush_o at N+1.
  - With a MEM stall, flush_o comes 1 cycle after stallreq_mem_i falls.
- new_pc_o holds its last latched value when flush_o = 0.
- Reset values: stall_o = 0, flush_o = 0, new_pc_o = `ZERO_WORD`, timeout_o = 0, counter = 0, state RUN. While rst is high all outputs are forced to these values regardless of inputs.
- Reset asserted mid-FLUSH_PEND or mid-STALL discards the latched PC and the counter; no flush is issued.

## Configuration
- `PIPE_CTRL_PERF_EN` defined adds two outputs:
  - stall_cycles_o, 32 bits: cycles with stall_o != 0
  - flush_count_o, 32 bits: flush_o pulses
- Both counters wrap at 2^32 and reset to 0.
- Without the macro, neither port nor either counter exists. All other behaviour is identical.

## Structure
- DEFINE.v gains:
  - STALL_* bit indices
  - the four stall encodings (`STALL_NONE`, `STALL_ID`, `STALL_EX`, `STALL_MEM`)
  - FSM state encodings (2-bit)
  - `FLUSH_ENABLE` and `FLUSH_DISABLE`
- One sub-module, `pipe_ctrl_perf`, holds the two performance counters. It is instantiated only under `PIPE_CTRL_PERF_EN`.

## Test plan
- stallreq_id_i high for 3 cycles → stall_o = 6'b000111 in exactly those 3 cycles, then 0; flush_o stays 0.
- stallreq_id_i and stallreq_mem_i high together → stall_o = 6'b011111; drop mem only → 6'b000111 the same cycle.
- flushreq_i with flush_pc_i = 32'h0000_0040 and no stall → next cycle flush_o = 1, new_pc_o = 32'h40; one cycle later flush_o = 0.
- Hold stallreq_mem_i 4 cycles, pulse flushreq_i (PC 32'h80) in cycle 1, then flushreq_i (PC 32'hC0) in cycle 2 → a single flush_o occurs 1 cycle after mem drops, with new_pc_o = 32'hC0.
- STALL_TIMEOUT = 8, stallreq_ex_i held 10 cycles → timeout_o rises on the 8th stall cycle and stays high after the stall ends until rst.
- Assert rst during FLUSH_PEND → no flush_o afterwards; all outputs are 0 in the rst cycle and the next cycle.
